// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard controller: the FSM state encoding
// and the widths of the register specifiers and counters.
package mips_pkg;

    localparam int REG_W       = 5;
    localparam int MD_LEN_W    = 6;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MD_BUSY  = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_controller_if;
    import mips_pkg::*;

    logic                   memread_idex;
    logic [REG_W-1:0]       rt_idex;
    logic [REG_W-1:0]       rs_ifid;
    logic [REG_W-1:0]       rt_ifid;
    logic                   branch_taken_ex;
    logic                   md_start;
    logic [MD_LEN_W-1:0]    md_len;
    logic                   dmem_req;
    logic                   dmem_ready;
    logic                   stall_clr;

    logic                   pc_en;
    logic                   ifid_en;
    logic                   idex_en;
    logic                   exmem_en;
    logic                   ifid_flush;
    logic                   idex_flush;
    logic                   md_busy;
    logic                   md_done;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output memread_idex, rt_idex, rs_ifid, rt_ifid, branch_taken_ex,
               md_start, md_len, dmem_req, dmem_ready, stall_clr,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               md_busy, md_done, stall_cycles
    );

    modport slave (
        input  memread_idex, rt_idex, rs_ifid, rt_ifid, branch_taken_ex,
               md_start, md_len, dmem_req, dmem_ready, stall_clr,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               md_busy, md_done, stall_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use compare: a load in ID/EX whose destination feeds the instruction in IF/ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic             memread_idex,
    input  logic [REG_W-1:0] rt_idex,
    input  logic [REG_W-1:0] rs_ifid,
    input  logic [REG_W-1:0] rt_ifid,
    output logic             lu_hazard
);

    // $zero is never a real dependency
    assign lu_hazard = memread_idex && (rt_idex != '0) &&
                       ((rt_idex == rs_ifid) || (rt_idex == rt_ifid));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, multi-cycle
// mult/div freeze, data-memory wait states and a saturating stall counter.
module hazard_controller
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    hazard_controller_if.slave bus
);

    logic                   lu_hazard;
    logic                   mem_stall;
    logic [MD_LEN_W-1:0]    md_load;
    state_t                 state;
    state_t                 state_next;
    logic [MD_LEN_W-1:0]    md_cnt;
    logic [MD_LEN_W-1:0]    md_cnt_next;
    logic                   md_done_set;
    logic                   md_done;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   pc_en_c;
    logic                   ifid_en_c;
    logic                   idex_en_c;
    logic                   exmem_en_c;
    logic                   ifid_flush_c;
    logic                   idex_flush_c;
    logic                   md_busy_c;

    load_use_detect u_load_use_detect (
        .memread_idex (bus.memread_idex),
        .rt_idex      (bus.rt_idex),
        .rs_ifid      (bus.rs_ifid),
        .rt_ifid      (bus.rt_ifid),
        .lu_hazard    (lu_hazard)
    );

    assign mem_stall = bus.dmem_req && !bus.dmem_ready;
    assign md_load   = (bus.md_len == '0) ? '0 : bus.md_len - MD_LEN_W'(1);

    // The issue cycle is the first busy cycle, so md_cnt holds the cycles
    // still to run; MD_BUSY expires on the cycle whose decrement reaches zero.
    always_comb begin
        state_next   = state;
        md_cnt_next  = md_cnt;
        md_done_set  = 1'b0;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        md_busy_c    = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    idex_en_c  = 1'b0;
                    exmem_en_c = 1'b0;
                    state_next = MEM_WAIT;
                end else if (bus.md_start) begin
                    pc_en_c     = 1'b0;
                    ifid_en_c   = 1'b0;
                    idex_en_c   = 1'b0;
                    md_cnt_next = md_load;
                    if (md_load != '0) state_next  = MD_BUSY;
                    else               md_done_set = 1'b1;
                end else if (bus.branch_taken_ex) begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (lu_hazard) begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            MD_BUSY: begin
                md_busy_c  = 1'b1;
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = !mem_stall;
                if (md_cnt != '0) md_cnt_next = md_cnt - MD_LEN_W'(1);
                if (md_cnt <= MD_LEN_W'(1)) begin
                    md_done_set = 1'b1;
                    state_next  = mem_stall ? MEM_WAIT : RUN;
                end
            end
            MEM_WAIT: begin
                pc_en_c    = bus.dmem_ready;
                ifid_en_c  = bus.dmem_ready;
                idex_en_c  = bus.dmem_ready;
                exmem_en_c = bus.dmem_ready;
                if (bus.dmem_ready) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            md_cnt       <= '0;
            md_done      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_next;
            md_cnt  <= md_cnt_next;
            md_done <= md_done_set;
            if (bus.stall_clr)
                stall_cycles <= '0;
            else if (!pc_en_c && (stall_cycles != '1))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

    // Reset holds every stage frozen with no bubbles injected
    assign bus.pc_en        = reset_n && pc_en_c;
    assign bus.ifid_en      = reset_n && ifid_en_c;
    assign bus.idex_en      = reset_n && idex_en_c;
    assign bus.exmem_en     = reset_n && exmem_en_c;
    assign bus.ifid_flush   = reset_n && ifid_flush_c;
    assign bus.idex_flush   = reset_n && idex_flush_c;
    assign bus.md_busy      = reset_n && md_busy_c;
    assign bus.md_done      = md_done;
    assign bus.stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a per-cycle expected-output scoreboard.
module tb_hazard_controller;
    import mips_pkg::*;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [15:0] stall;
    } exp_t;

    // ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, md_busy, md_done}
    localparam logic [7:0] C_IDLE = 8'b1111_0000;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_MDS  = 8'b0001_0000;
    localparam logic [7:0] C_MDB  = 8'b0001_0010;
    localparam logic [7:0] C_DONE = 8'b1111_0001;
    localparam logic [7:0] C_FRZ  = 8'b0000_0000;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fails;
    exp_t sb[$];

    hazard_controller_if ifc ();

    hazard_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                          input logic [4:0] rt_id, input logic br, input logic mds,
                          input logic [5:0] mdl, input logic dreq, input logic drdy,
                          input logic clr);
        ifc.memread_idex    = mr;
        ifc.rt_idex         = rt_ex;
        ifc.rs_ifid         = rs_id;
        ifc.rt_ifid         = rt_id;
        ifc.branch_taken_ex = br;
        ifc.md_start        = mds;
        ifc.md_len          = mdl;
        ifc.dmem_req        = dreq;
        ifc.dmem_ready      = drdy;
        ifc.stall_clr       = clr;
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic step(input string tag, input logic [7:0] ctl, input logic [15:0] stall);
        exp_t e;
        logic [7:0] obs;
        sb.push_back('{ctl: ctl, stall: stall});
        #1;
        e   = sb.pop_front();
        obs = {ifc.pc_en, ifc.ifid_en, ifc.idex_en, ifc.exmem_en,
               ifc.ifid_flush, ifc.idex_flush, ifc.md_busy, ifc.md_done};
        n_checks++;
        assert (obs === e.ctl) else begin
            n_fails++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e.ctl);
        end
        n_checks++;
        assert (ifc.stall_cycles === e.stall) else begin
            n_fails++;
            $error("FAIL %s stall_cycles observed=%h expected=%h", tag, ifc.stall_cycles, e.stall);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset", C_FRZ, 16'd0);
        reset_n = 1'b1;
        step("idle0", C_IDLE, 16'd0);

        // load-use on rs, then rt_idex==0, rt match, no load, branch override
        set_in(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);  step("lu_rs", C_LU, 16'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("lu_after", C_IDLE, 16'd1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("lu_r0", C_IDLE, 16'd1);
        set_in(1, 7, 3, 7, 0, 0, 0, 0, 0, 0);  step("lu_rt", C_LU, 16'd1);
        set_in(0, 7, 3, 7, 0, 0, 0, 0, 0, 0);  step("no_load", C_IDLE, 16'd2);
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);  step("branch_lu", C_BR, 16'd2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("br_after", C_IDLE, 16'd2);

        // stall_clr, including clear against a simultaneous increment
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("clr_idle", C_IDLE, 16'd2);
        set_in(1, 5, 5, 0, 0, 0, 0, 0, 0, 1);  step("clr_lu", C_LU, 16'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("clr_prio", C_IDLE, 16'd0);

        // mult/div of 4 cycles; branch during MD_BUSY is held off
        set_in(0, 0, 0, 0, 0, 1, 4, 0, 0, 0);  step("md4_issue", C_MDS, 16'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("md4_b1", C_MDB, 16'd1);
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);  step("md4_b2", C_MDB, 16'd2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("md4_b3", C_MDB, 16'd3);
        step("md4_done", C_DONE, 16'd4);
        step("md4_after", C_IDLE, 16'd4);

        // md_len 0 acts as 1
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);  step("md0_issue", C_MDS, 16'd4);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("md0_done", C_DONE, 16'd5);
        step("md0_after", C_IDLE, 16'd5);

        // memory wait of three cycles
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  step("mem_w0", C_FRZ, 16'd5);
        step("mem_w1", C_FRZ, 16'd6);
        step("mem_w2", C_FRZ, 16'd7);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  step("mem_rdy", C_IDLE, 16'd8);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mem_after", C_IDLE, 16'd8);

        // memory stall outranks md_start; ready access does not stall
        set_in(0, 0, 0, 0, 0, 1, 4, 1, 0, 0);  step("mem_vs_md", C_FRZ, 16'd8);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  step("mem_vs_md_rdy", C_IDLE, 16'd9);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mem_vs_md_run", C_IDLE, 16'd9);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  step("mem_hit", C_IDLE, 16'd9);

        // MD_BUSY expiry while memory is stalled goes to MEM_WAIT
        set_in(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);  step("mdm_issue", C_MDS, 16'd9);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mdm_b1", C_MDB, 16'd10);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  step("mdm_b2", 8'b0000_0010, 16'd11);
        step("mdm_wait", 8'b0000_0001, 16'd12);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  step("mdm_rdy", C_IDLE, 16'd13);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mdm_after", C_IDLE, 16'd13);

        // reset mid-MD_BUSY abandons without md_done
        set_in(0, 0, 0, 0, 0, 1, 5, 0, 0, 0);  step("mdr_issue", C_MDS, 16'd13);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mdr_b1", C_MDB, 16'd14);
        reset_n = 1'b0;                        step("mdr_reset", C_FRZ, 16'd0);
        reset_n = 1'b1;                        step("mdr_run", C_IDLE, 16'd0);
        step("mdr_nodone", C_IDLE, 16'd0);

        // reset mid-MEM_WAIT abandons the wait
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  step("mwr_w0", C_FRZ, 16'd0);
        step("mwr_w1", C_FRZ, 16'd1);
        reset_n = 1'b0;                        step("mwr_reset", C_FRZ, 16'd0);
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("mwr_run", C_IDLE, 16'd0);

        // saturation after a very long memory wait
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (70000) @(negedge clk);
        step("sat_hold", C_FRZ, 16'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  step("sat_rdy", C_IDLE, 16'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("sat_clr", C_IDLE, 16'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("sat_zero", C_IDLE, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
